// File: rtl/tach_pulse_meter.sv
// Tachometer front end: 2-flop synchroniser, glitch filter, and pulse
// high-time/period measurement with a saturated 8-bit rate and stall timeout.
module tach_pulse_meter #(
  parameter int CNT_W      = 16,
  parameter int FILT_LEN   = 4,
  parameter int TIMEOUT    = 65535,
  parameter int RATE_SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tach_in,
  input  logic             clear,
  output logic [CNT_W-1:0] high_time,
  output logic [CNT_W-1:0] period,
  output logic [7:0]       rate,
  output logic             valid,
  output logic             stall
);

  localparam int FW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  logic          sync1, sync2;
  logic [FW-1:0] flt_cnt;
  logic          level, level_d;
  logic          rise, fall;

  logic [1:0]       state;
  logic [CNT_W-1:0] per_cnt, hi_cnt, hi_cap;
  logic [CNT_W-1:0] per_inc, hi_inc, hi_shift;
  logic [CNT_W+7:0] hi_shift_x;
  logic [7:0]       rate_n;
  logic             timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= tach_in;
      sync2 <= sync1;
    end
  end

  // clear leaves level/level_d alone so a line held high never fakes a rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_cnt <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level;
      if (clear) begin
        flt_cnt <= '0;
      end else if (sync2 != level) begin
        if (flt_cnt == FW'(FILT_LEN - 1)) begin
          level   <= ~level;
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

  assign per_inc     = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
  assign hi_inc      = (hi_cnt == '1) ? hi_cnt : hi_cnt + 1'b1;
  assign hi_shift    = hi_cap >> RATE_SHIFT;
  assign hi_shift_x  = {8'd0, hi_shift};
  assign rate_n      = (hi_shift_x > (CNT_W + 8)'(255)) ? 8'hff : hi_shift_x[7:0];
  assign timeout_hit = (per_cnt == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      hi_cap    <= '0;
      high_time <= '0;
      period    <= '0;
      rate      <= '0;
      valid     <= 1'b0;
      stall     <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      hi_cap    <= '0;
      high_time <= '0;
      period    <= '0;
      rate      <= '0;
      valid     <= 1'b0;
      stall     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        // only a rise closing a full high+low cycle carries a measurement
        if (state == LOW) begin
          period    <= per_cnt;
          high_time <= hi_cap;
          rate      <= rate_n;
          valid     <= 1'b1;
          stall     <= 1'b0;
        end
        per_cnt <= CNT_W'(1);
        hi_cnt  <= CNT_W'(1);
        state   <= HIGH;
      end else if (timeout_hit) begin
        stall     <= 1'b1;
        period    <= '0;
        high_time <= '0;
        rate      <= '0;
        per_cnt   <= '0;
        hi_cnt    <= '0;
        state     <= IDLE;
      end else begin
        per_cnt <= per_inc;
        if (state == HIGH) begin
          hi_cnt <= hi_inc;
          if (fall) begin
            hi_cap <= hi_cnt;
            state  <= LOW;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tach_pulse_meter.sv
// Directed bench for tach_pulse_meter: square waves, glitches, stall timeout,
// rate saturation, async reset and soft clear.
module tb_tach_pulse_meter;
  localparam int CNT_W    = 16;
  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 1000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tach_in = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] high_time, period;
  logic [7:0]       rate;
  logic             valid, stall;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int vcnt = 0;
  int v0 = 0;
  int last_rise = 0;
  int stall_cyc = -1;
  logic [CNT_W-1:0] cap_p = '0, cap_h = '0;
  logic [7:0]       cap_r = '0;
  logic             cap_s = 1'b0;
  logic             stall_d = 1'b0;

  tach_pulse_meter #(.CNT_W(CNT_W), .FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT), .RATE_SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .tach_in(tach_in), .clear(clear),
    .high_time(high_time), .period(period), .rate(rate), .valid(valid), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Hold tach_in at lvl for n cycles, recording every valid strobe and the stall onset
  task automatic run(input logic lvl, input int n);
    if (lvl && !tach_in) last_rise = cyc;
    tach_in = lvl;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (valid) begin
        vcnt++;
        cap_p = period; cap_h = high_time; cap_r = rate; cap_s = stall;
      end
      if (stall && !stall_d) stall_cyc = cyc;
      stall_d = stall;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period got %0d exp 0", period); end
    checks++; if (high_time !== 16'd0) begin errors++; $display("FAIL reset_high got %0d exp 0", high_time); end
    checks++; if (rate !== 8'd0) begin errors++; $display("FAIL reset_rate got %0d exp 0", rate); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    rst_n = 1'b1;
  endtask

  task automatic test_square;
    v0 = vcnt;
    for (int k = 0; k < 4; k++) begin
      run(1'b1, 40);
      run(1'b0, 60);
    end
    checks++; if (vcnt - v0 !== 3) begin errors++; $display("FAIL sq_valid_count got %0d exp 3", vcnt - v0); end
    checks++; if (cap_p !== 16'd100) begin errors++; $display("FAIL sq_period got %0d exp 100", cap_p); end
    checks++; if (cap_h !== 16'd40) begin errors++; $display("FAIL sq_high got %0d exp 40", cap_h); end
    checks++; if (cap_r !== 8'd40) begin errors++; $display("FAIL sq_rate got %0d exp 40", cap_r); end
    checks++; if (cap_s !== 1'b0) begin errors++; $display("FAIL sq_stall got %b exp 0", cap_s); end
  endtask

  task automatic test_glitch;
    clear = 1'b1; run(1'b0, 1); clear = 1'b0;
    v0 = vcnt;
    run(1'b1, FILT_LEN - 1);
    run(1'b0, 50);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL glitch3_valid got %0d exp 0", vcnt - v0); end
    run(1'b1, FILT_LEN);
    run(1'b0, 96);
    run(1'b1, 10);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL glitch4_valid got %0d exp 1", vcnt - v0); end
    checks++; if (cap_h !== 16'd4) begin errors++; $display("FAIL glitch4_high got %0d exp 4", cap_h); end
    checks++; if (cap_p !== 16'd100) begin errors++; $display("FAIL glitch4_period got %0d exp 100", cap_p); end
  endtask

  task automatic test_stall;
    run(1'b1, 30);
    stall_cyc = -1;
    v0 = vcnt;
    run(1'b0, 1100);
    // input rise -> filtered level 2+FILT_LEN, counter restarts 1 later, then TIMEOUT counts
    checks++; if (stall_cyc - last_rise !== TIMEOUT + FILT_LEN + 3) begin errors++; $display("FAIL stall_time got %0d exp %0d", stall_cyc - last_rise, TIMEOUT + FILT_LEN + 3); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_flag got %b exp 1", stall); end
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL stall_period got %0d exp 0", period); end
    checks++; if (high_time !== 16'd0) begin errors++; $display("FAIL stall_high got %0d exp 0", high_time); end
    checks++; if (rate !== 8'd0) begin errors++; $display("FAIL stall_rate got %0d exp 0", rate); end
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL stall_valid got %0d exp 0", vcnt - v0); end
    run(1'b1, 40);
    run(1'b0, 60);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_hold got %b exp 1", stall); end
    run(1'b1, 40);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL restart_valid got %0d exp 1", vcnt - v0); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL restart_stall got %b exp 0", stall); end
    checks++; if (cap_p !== 16'd100) begin errors++; $display("FAIL restart_period got %0d exp 100", cap_p); end
    checks++; if (cap_h !== 16'd40) begin errors++; $display("FAIL restart_high got %0d exp 40", cap_h); end
  endtask

  task automatic test_saturate;
    v0 = vcnt;
    run(1'b0, 60);
    run(1'b1, 300);
    run(1'b0, 200);
    run(1'b1, 20);
    checks++; if (vcnt - v0 !== 2) begin errors++; $display("FAIL sat_valid got %0d exp 2", vcnt - v0); end
    checks++; if (cap_h !== 16'd300) begin errors++; $display("FAIL sat_high got %0d exp 300", cap_h); end
    checks++; if (cap_p !== 16'd500) begin errors++; $display("FAIL sat_period got %0d exp 500", cap_p); end
    checks++; if (cap_r !== 8'd255) begin errors++; $display("FAIL sat_rate got %0d exp 255", cap_r); end
    checks++; if (rate !== 8'd255) begin errors++; $display("FAIL sat_rate_out got %0d exp 255", rate); end
  endtask

  task automatic test_async_reset;
    run(1'b1, 10);
    rst_n = 1'b0;
    #2;
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL areset_period got %0d exp 0", period); end
    checks++; if (high_time !== 16'd0) begin errors++; $display("FAIL areset_high got %0d exp 0", high_time); end
    checks++; if (rate !== 8'd0) begin errors++; $display("FAIL areset_rate got %0d exp 0", rate); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL areset_stall got %b exp 0", stall); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    v0 = vcnt;
    run(1'b1, 40);
    run(1'b0, 60);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL areset_early_valid got %0d exp 0", vcnt - v0); end
    run(1'b1, 20);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL areset_valid_count got %0d exp 1", vcnt - v0); end
    checks++; if (cap_p !== 16'd100) begin errors++; $display("FAIL areset_period2 got %0d exp 100", cap_p); end
    checks++; if (cap_h !== 16'd40) begin errors++; $display("FAIL areset_high2 got %0d exp 40", cap_h); end
  endtask

  task automatic test_clear_on_rise;
    run(1'b0, 60);
    v0 = vcnt;
    // filtered rise strobe is live during the cycle after 2+FILT_LEN edges
    run(1'b1, FILT_LEN + 2);
    clear = 1'b1; run(1'b1, 1); clear = 1'b0;
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL clr_valid got %0d exp 0", vcnt - v0); end
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL clr_period got %0d exp 0", period); end
    checks++; if (high_time !== 16'd0) begin errors++; $display("FAIL clr_high got %0d exp 0", high_time); end
    checks++; if (rate !== 8'd0) begin errors++; $display("FAIL clr_rate got %0d exp 0", rate); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL clr_stall got %b exp 0", stall); end
    run(1'b1, 33);
    run(1'b0, 60);
    run(1'b1, 40);
    run(1'b0, 60);
    checks++; if (vcnt - v0 !== 0) begin errors++; $display("FAIL clr_early_valid got %0d exp 0", vcnt - v0); end
    run(1'b1, 20);
    checks++; if (vcnt - v0 !== 1) begin errors++; $display("FAIL clr_valid_count got %0d exp 1", vcnt - v0); end
    checks++; if (cap_p !== 16'd100) begin errors++; $display("FAIL clr_period2 got %0d exp 100", cap_p); end
    checks++; if (cap_h !== 16'd40) begin errors++; $display("FAIL clr_high2 got %0d exp 40", cap_h); end
  endtask

  initial begin
    test_reset();
    test_square();
    test_glitch();
    test_stall();
    test_saturate();
    test_async_reset();
    test_clear_on_rise();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
